// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART AXI-Lite arbiter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ADDR  = 3'd1,
    RD_DATA  = 3'd2,
    WR_ADDR  = 3'd3,
    WR_RESP  = 3'd4,
    ERR_RESP = 3'd5
  } arb_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } arb_op_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping at N.
module uart_rr_pick #(
  parameter int N  = 2,
  parameter int GW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] idx,
  output logic          found
);

  always_comb begin
    int c;
    c     = 0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = GW'(c);
      end
    end
  end

endmodule

// File: rtl/uart_axi_arbiter.sv
// N:1 AXI4-Lite arbiter in front of the UART buffer slave port; one transaction in flight.
// Optional slave-silence timeout with SLVERR response: define ARB_TIMEOUT_EN.
module uart_axi_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_araddr,
  input  logic [N_MASTERS-1:0]          m_arvalid,
  output logic [N_MASTERS-1:0]          m_arready,
  output logic [31:0]                   m_rdata,
  output logic [1:0]                    m_rresp,
  output logic [N_MASTERS-1:0]          m_rvalid,
  input  logic [N_MASTERS-1:0]          m_rready,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_awaddr,
  input  logic [N_MASTERS-1:0]          m_awvalid,
  output logic [N_MASTERS-1:0]          m_awready,
  input  logic [N_MASTERS*32-1:0]       m_wdata,
  input  logic [N_MASTERS*4-1:0]        m_wstrb,
  input  logic [N_MASTERS-1:0]          m_wvalid,
  output logic [N_MASTERS-1:0]          m_wready,
  output logic [1:0]                    m_bresp,
  output logic [N_MASTERS-1:0]          m_bvalid,
  input  logic [N_MASTERS-1:0]          m_bready,
  output logic [ADDR_W-1:0]             s_araddr,
  output logic                          s_arvalid,
  input  logic                          s_arready,
  input  logic [31:0]                   s_rdata,
  input  logic [1:0]                    s_rresp,
  input  logic                          s_rvalid,
  output logic                          s_rready,
  output logic [ADDR_W-1:0]             s_awaddr,
  output logic                          s_awvalid,
  input  logic                          s_awready,
  output logic [31:0]                   s_wdata,
  output logic [3:0]                    s_wstrb,
  output logic                          s_wvalid,
  input  logic                          s_wready,
  input  logic [1:0]                    s_bresp,
  input  logic                          s_bvalid,
  output logic                          s_bready,
  output logic [2:0]                    s_arprot,
  output logic [2:0]                    s_awprot,
  output logic [$clog2(N_MASTERS)-1:0]  grant_idx,
  output logic                          busy
);

  localparam int GW = $clog2(N_MASTERS);

  if (N_MASTERS < 2 || TIMEOUT < 1) begin : g_param_chk
    $error("uart_axi_arbiter: need N_MASTERS >= 2 and TIMEOUT >= 1");
  end

  arb_state_e         state_q, state_d;
  logic [GW-1:0]      gnt_q, gnt_d;
  logic [GW-1:0]      ptr_q, ptr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;

  logic [N_MASTERS-1:0] req;
  logic [GW-1:0]        pick_idx;
  logic                 pick_found;
  arb_op_e              pick_op;

  // A write is only eligible once both its AW and W beats are presented.
  assign req     = m_arvalid | (m_awvalid & m_wvalid);
  assign pick_op = m_arvalid[pick_idx] ? OP_RD : OP_WR;

  uart_rr_pick #(.N(N_MASTERS), .GW(GW)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  arb_op_e       op_q, op_d;
  logic          slv_hs;

  assign slv_hs = ((state_q == RD_ADDR) & s_arready) |
                  ((state_q == RD_DATA) & s_rvalid & m_rready[gnt_q]) |
                  ((state_q == WR_ADDR) & ((~aw_done_q & s_awready) | (~w_done_q & s_wready))) |
                  ((state_q == WR_RESP) & s_bvalid & m_bready[gnt_q]);
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ptr_q     <= GW'(N_MASTERS - 1);
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      op_q      <= OP_RD;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      op_q      <= op_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifdef ARB_TIMEOUT_EN
    op_d      = op_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d     = pick_idx;
          ptr_d     = pick_idx;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
          op_d      = pick_op;
`endif
          if (pick_op == OP_RD) begin
            addr_d  = m_araddr[int'(pick_idx)*ADDR_W +: ADDR_W];
            state_d = RD_ADDR;
          end else begin
            addr_d  = m_awaddr[int'(pick_idx)*ADDR_W +: ADDR_W];
            wdata_d = m_wdata[int'(pick_idx)*32 +: 32];
            wstrb_d = m_wstrb[int'(pick_idx)*4 +: 4];
            state_d = WR_ADDR;
          end
        end
      end
      RD_ADDR: if (s_arready) state_d = RD_DATA;
      RD_DATA: if (s_rvalid && m_rready[gnt_q]) state_d = IDLE;
      WR_ADDR: begin
        // AW and W complete independently; leave once both are done.
        aw_done_d = aw_done_q | s_awready;
        w_done_d  = w_done_q | s_wready;
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: if (s_bvalid && m_bready[gnt_q]) state_d = IDLE;
`ifdef ARB_TIMEOUT_EN
      ERR_RESP: begin
        if ((op_q == OP_RD) ? m_rready[gnt_q] : m_bready[gnt_q]) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef ARB_TIMEOUT_EN
    cnt_d = '0;
    if (state_q inside {RD_ADDR, RD_DATA, WR_ADDR, WR_RESP}) begin
      if (slv_hs)
        cnt_d = '0;
      else if (cnt_q == CW'(TIMEOUT - 1))
        state_d = ERR_RESP;
      else
        cnt_d = cnt_q + 1'b1;
    end
`endif
  end

  always_comb begin
    m_arready = '0;
    m_awready = '0;
    m_wready  = '0;
    m_rvalid  = '0;
    m_bvalid  = '0;
    m_rdata   = '0;
    m_rresp   = RESP_OKAY;
    m_bresp   = RESP_OKAY;
    s_arvalid = 1'b0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_rready  = 1'b0;
    s_bready  = 1'b0;
    case (state_q)
      IDLE: begin
`ifdef ARB_TIMEOUT_EN
        // Sink stray responses from transactions already abandoned by timeout.
        s_rready = 1'b1;
        s_bready = 1'b1;
`endif
        if (pick_found) begin
          if (pick_op == OP_RD) begin
            m_arready[pick_idx] = 1'b1;
          end else begin
            m_awready[pick_idx] = 1'b1;
            m_wready[pick_idx]  = 1'b1;
          end
        end
      end
      RD_ADDR: s_arvalid = 1'b1;
      RD_DATA: begin
        m_rvalid[gnt_q] = s_rvalid;
        s_rready        = m_rready[gnt_q];
        m_rdata         = s_rdata;
        m_rresp         = s_rresp;
      end
      WR_ADDR: begin
        s_awvalid = ~aw_done_q;
        s_wvalid  = ~w_done_q;
      end
      WR_RESP: begin
        m_bvalid[gnt_q] = s_bvalid;
        s_bready        = m_bready[gnt_q];
        m_bresp         = s_bresp;
      end
`ifdef ARB_TIMEOUT_EN
      ERR_RESP: begin
        if (op_q == OP_RD) begin
          m_rvalid[gnt_q] = 1'b1;
          m_rresp         = RESP_SLVERR;
        end else begin
          m_bvalid[gnt_q] = 1'b1;
          m_bresp         = RESP_SLVERR;
        end
      end
`endif
      default: ;
    endcase
  end

  assign s_araddr  = addr_q;
  assign s_awaddr  = addr_q;
  assign s_wdata   = wdata_q;
  assign s_wstrb   = wstrb_q;
  assign s_arprot  = 3'b000;
  assign s_awprot  = 3'b000;
  assign grant_idx = gnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_axi_arbiter.sv
// Random masters and a random-latency slave around uart_axi_arbiter, checked against a transaction-level model.
module tb_uart_axi_arbiter;
  localparam int NM  = 3;
  localparam int AW  = 4;
  localparam int TMO = 16;
  localparam int GW  = $clog2(NM);
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0, rstn = 1'b0;
  logic [NM*AW-1:0] m_araddr, m_awaddr;
  logic [NM-1:0] m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
  logic [NM-1:0] m_wvalid, m_wready, m_bvalid, m_bready;
  logic [31:0] m_rdata;
  logic [1:0] m_rresp, m_bresp;
  logic [NM*32-1:0] m_wdata;
  logic [NM*4-1:0] m_wstrb;
  logic [AW-1:0] s_araddr, s_awaddr;
  logic s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_rdata, s_wdata;
  logic [3:0] s_wstrb;
  logic [1:0] s_rresp, s_bresp;
  logic [2:0] s_arprot, s_awprot;
  logic [GW-1:0] grant_idx;
  logic busy;

  uart_axi_arbiter #(.N_MASTERS(NM), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arprot(s_arprot), .s_awprot(s_awprot), .grant_idx(grant_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // master-side intent
  bit rd_p[NM], wr_p[NM], rd_out[NM], wr_out[NM];
  logic [AW-1:0] ra[NM], wa[NM];
  logic [31:0] wd[NM];
  logic [3:0] ws[NM];
  int wdly[NM];
  // arbitration model
  bit owned, own_wr;
  int own, last;
  logic [GW-1:0] gexp;
  logic [AW-1:0] own_a;
  logic [31:0] own_d;
  logic [3:0] own_s;
  logic [31:0] sb[16], smem[16];
  // slave model
  bit rgot, awgot, wgot, bpend, rhs, bhs, hold_r;
  int rlat, blat;
  logic [AW-1:0] ra_s;
  logic [1:0] rresp_e, bresp_e;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[b*8 +: 8] = d[b*8 +: 8];
    return o;
  endfunction

  function automatic logic [NM-1:0] oh(input int i);
    logic [NM-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NM; i++) begin
      rd_p[i] = 0; wr_p[i] = 0; rd_out[i] = 0; wr_out[i] = 0; wdly[i] = 0;
    end
    owned = 0; own_wr = 0; own = 0; last = NM - 1; gexp = '0;
    rgot = 0; awgot = 0; wgot = 0; bpend = 0; rhs = 0; bhs = 0; hold_r = 0;
    m_araddr = '0; m_arvalid = '0; m_rready = '0; m_awaddr = '0; m_awvalid = '0;
    m_wdata = '0; m_wstrb = '0; m_wvalid = '0; m_bready = '0;
    s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0;
    s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < NM; i++) begin
      if (!rd_p[i] && !rd_out[i] && $urandom_range(3) == 0) begin
        rd_p[i] = 1; ra[i] = AW'($urandom);
      end
      if (!wr_p[i] && !wr_out[i] && $urandom_range(4) == 0) begin
        wr_p[i] = 1; wa[i] = AW'($urandom); wd[i] = $urandom; ws[i] = 4'($urandom);
        wdly[i] = $urandom_range(2);
      end else if (wdly[i] > 0) wdly[i]--;
      m_arvalid[i] = rd_p[i];
      m_araddr[i*AW +: AW] = ra[i];
      m_awvalid[i] = wr_p[i];
      m_wvalid[i] = wr_p[i] && (wdly[i] == 0);
      m_awaddr[i*AW +: AW] = wa[i];
      m_wdata[i*32 +: 32] = wd[i];
      m_wstrb[i*4 +: 4] = ws[i];
      m_rready[i] = ($urandom_range(3) != 0);
      m_bready[i] = ($urandom_range(3) != 0);
    end
    s_arready = ($urandom_range(3) != 0);
    if (rhs) begin s_rvalid = 0; rhs = 0; end
    if (!s_rvalid) s_rdata = $urandom;
    if (rgot && !s_rvalid && !hold_r) begin
      if (rlat == 0) begin
        s_rvalid = 1; s_rdata = smem[ra_s];
        rresp_e = $urandom_range(1) ? 2'b10 : 2'b00; s_rresp = rresp_e;
      end else rlat--;
    end
    s_awready = !awgot && ($urandom_range(3) != 0);
    s_wready  = !wgot && ($urandom_range(3) != 0);
    if (bhs) begin s_bvalid = 0; bhs = 0; end
    if (bpend && !s_bvalid) begin
      if (blat == 0) begin
        s_bvalid = 1; bresp_e = $urandom_range(1) ? 2'b10 : 2'b00; s_bresp = bresp_e;
      end else blat--;
    end
  endtask

  task automatic observe();
    logic [NM-1:0] req, e_ar, e_aw, e, z;
    int w, c;
    z = '0; w = -1;
    req = m_arvalid | (m_awvalid & m_wvalid);
    chk("busy", busy, owned);
    chk("grant_idx", grant_idx, gexp);
    e_ar = z; e_aw = z;
    if (!owned)
      for (int k = 1; k <= NM; k++) begin
        c = (last + k) % NM;
        if (w < 0 && req[c]) w = c;
      end
    if (w >= 0) begin
      if (m_arvalid[w]) e_ar[w] = 1'b1; else e_aw[w] = 1'b1;
    end
    chk("arready", m_arready, e_ar);
    chk("awready", m_awready, e_aw);
    chk("wready", m_wready, e_aw);
    if (!owned) begin
      chk("rvalid_idle", m_rvalid, z);
      chk("bvalid_idle", m_bvalid, z);
      chk("s_valid_idle", {s_arvalid, s_awvalid, s_wvalid}, 0);
      chk("s_ready_idle", {s_rready, s_bready}, TMO_EN ? 2'b11 : 2'b00);
    end else if (!own_wr) begin
      chk("bvalid_rd", m_bvalid, z);
      chk("aw_w_rd", {s_awvalid, s_wvalid}, 0);
      if (!rgot) begin
        chk("s_arvalid", s_arvalid, 1);
        chk("s_araddr", s_araddr, own_a);
        chk("rvalid_wait", m_rvalid, z);
        if (s_arready) begin rgot = 1; ra_s = s_araddr; rlat = $urandom_range(3); end
      end else begin
        e = s_rvalid ? oh(own) : z;
        chk("m_rvalid", m_rvalid, e);
        chk("s_rready", s_rready, m_rready[own]);
        chk("s_arvalid_done", s_arvalid, 0);
        if (s_rvalid && m_rready[own]) begin
          chk("m_rdata", m_rdata, sb[own_a]);
          chk("m_rresp", m_rresp, rresp_e);
          owned = 0; rd_out[own] = 0; rgot = 0; rhs = 1;
        end
      end
    end else begin
      chk("rvalid_wr", m_rvalid, z);
      chk("s_arvalid_wr", s_arvalid, 0);
      if (awgot && wgot) begin
        e = s_bvalid ? oh(own) : z;
        chk("m_bvalid", m_bvalid, e);
        chk("s_bready", s_bready, m_bready[own]);
        chk("aw_w_done", {s_awvalid, s_wvalid}, 0);
        if (s_bvalid && m_bready[own]) begin
          chk("m_bresp", m_bresp, bresp_e);
          sb[own_a] = merge(sb[own_a], own_d, own_s);
          owned = 0; wr_out[own] = 0; awgot = 0; wgot = 0; bpend = 0; bhs = 1;
        end
      end else begin
        chk("bvalid_wait", m_bvalid, z);
        chk("s_awvalid", s_awvalid, !awgot);
        chk("s_wvalid", s_wvalid, !wgot);
        chk("s_awaddr", s_awaddr, own_a);
        chk("s_wdata", s_wdata, own_d);
        chk("s_wstrb", s_wstrb, own_s);
        if (!awgot && s_awready) awgot = 1;
        if (!wgot && s_wready) wgot = 1;
        if (awgot && wgot) begin
          bpend = 1; blat = $urandom_range(3);
          smem[own_a] = merge(smem[own_a], s_wdata, s_wstrb);
        end
      end
    end
    if (w >= 0) begin
      owned = 1; own = w; last = w; gexp = GW'(w);
      if (m_arvalid[w]) begin
        own_wr = 0; own_a = ra[w]; rd_p[w] = 0; rd_out[w] = 1;
      end else begin
        own_wr = 1; own_a = wa[w]; own_d = wd[w]; own_s = ws[w]; wr_p[w] = 0; wr_out[w] = 1;
      end
    end
  endtask

  initial begin
    bit reached;
    model_reset();
    for (int a = 0; a < 16; a++) begin smem[a] = $urandom; sb[a] = smem[a]; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_readies", {m_arready, m_awready, m_wready}, 0);
    chk("rst_valids", {m_rvalid, m_bvalid, s_arvalid, s_awvalid, s_wvalid}, 0);
    chk("rst_s_ready", {s_rready, s_bready}, TMO_EN ? 2'b11 : 2'b00);
    chk("rst_data", m_rdata | s_wdata, 0);
    chk("rst_resp", {m_rresp, m_bresp}, 0);
    chk("rst_gidx", grant_idx, 0);
    chk("prot", {s_arprot, s_awprot}, 0);
    @(posedge clk); #1 rstn = 1'b1;

    for (int cy = 0; cy < 4000; cy++) begin
      drive();
      @(negedge clk);
      observe();
      @(posedge clk); #1;
    end

    // reset while a read waits in RD_DATA with the slave holding rvalid low
    hold_r = 1; reached = 0;
    for (int cy = 0; cy < 500 && !reached; cy++) begin
      drive();
      @(negedge clk);
      observe();
      if (owned && !own_wr && rgot && !s_rvalid) reached = 1;
      @(posedge clk); #1;
    end
    chk("rst_reach", reached, 1);
    @(negedge clk);
    chk("busy_pre_rst", busy, 1);
    @(posedge clk); #1 rstn = 1'b0;
    model_reset();
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valids", {m_rvalid, m_bvalid, s_arvalid, s_awvalid, s_wvalid}, 0);
    chk("mid_rst_gidx", grant_idx, 0);
    @(posedge clk); #1 m_arvalid = '1;
    @(negedge clk);
    chk("mid_rst_first_grant", m_arready, 3'b001);
    @(posedge clk); #1 m_arvalid = '0;
    s_arready = 1'b1;
    @(posedge clk); #1 s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0000_0001; s_rresp = 2'b00;
    m_rready = '1;
    @(negedge clk);
    chk("post_rst_rvalid", m_rvalid, 3'b001);
    chk("post_rst_rdata", m_rdata, 32'h0000_0001);
    @(posedge clk); #1 s_rvalid = 1'b0; m_rready = '0;
    @(negedge clk);
    chk("post_rst_idle", busy, 0);

`ifdef ARB_TIMEOUT_EN
    begin
      int ncy;
      bit got;
      ncy = 0; got = 0;
      @(posedge clk); #1 m_arvalid = 3'b001; m_araddr = '0; s_arready = 1'b0;
      @(negedge clk);
      chk("tmo_grant", m_arready, 3'b001);
      @(posedge clk); #1 m_arvalid = '0;
      for (int cy = 0; cy < 60; cy++) begin
        @(negedge clk);
        if (s_arvalid) ncy++;
        if (m_rvalid[0]) begin got = 1; break; end
      end
      chk("tmo_seen", got, 1);
      chk("tmo_cycles", ncy, TMO);
      chk("tmo_rvalid", m_rvalid, 3'b001);
      chk("tmo_rresp", m_rresp, 2'b10);
      chk("tmo_rdata", m_rdata, 0);
      @(posedge clk); #1 m_rready = 3'b001;
      @(posedge clk); #1 m_rready = '0; s_rvalid = 1'b1; s_rdata = 32'hdead_beef;
      @(negedge clk);
      chk("tmo_idle", busy, 0);
      chk("tmo_late_fwd", m_rvalid, 0);
      chk("tmo_sink", s_rready, 1);
      @(posedge clk); #1 s_rvalid = 1'b0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_chk, n_err);
    $finish;
  end

endmodule
